// File: rtl/ipod_audio_pkg.sv
// Shared definitions for the Simple iPod audio path: tone type, note
// frequencies, half-period helper and tone FSM state encoding.
package ipod_audio_pkg;

    typedef logic [2:0] tone_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } tone_state_e;

    localparam int unsigned NOTE_DO_HZ  = 523;
    localparam int unsigned NOTE_RE_HZ  = 587;
    localparam int unsigned NOTE_MI_HZ  = 659;
    localparam int unsigned NOTE_FA_HZ  = 698;
    localparam int unsigned NOTE_SOL_HZ = 783;
    localparam int unsigned NOTE_LA_HZ  = 880;
    localparam int unsigned NOTE_SI_HZ  = 987;
    localparam int unsigned NOTE_DO2_HZ = 1046;

    function automatic int unsigned note_hz(input tone_t tone);
        int unsigned hz;
        case (tone)
            3'd0:    hz = NOTE_DO_HZ;
            3'd1:    hz = NOTE_RE_HZ;
            3'd2:    hz = NOTE_MI_HZ;
            3'd3:    hz = NOTE_FA_HZ;
            3'd4:    hz = NOTE_SOL_HZ;
            3'd5:    hz = NOTE_LA_HZ;
            3'd6:    hz = NOTE_SI_HZ;
            default: hz = NOTE_DO2_HZ;
        endcase
        return hz;
    endfunction

    // Half a square-wave period in clock cycles, truncated to 16 bits.
    function automatic logic [15:0] half_period(input tone_t tone, input int unsigned clk_hz);
        int unsigned cycles;
        cycles = clk_hz / (2 * note_hz(tone));
        return cycles[15:0];
    endfunction

endpackage

// File: rtl/tone_generator_if.sv
// Sample handshake bundle between the tone generator and the codec side.
interface tone_generator_if;

    logic [7:0] sample_data;
    logic       sample_valid;
    logic       sample_ready;
    logic       overrun;

    modport master (
        output sample_data,
        output sample_valid,
        output overrun,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_valid,
        input  overrun,
        output sample_ready
    );

endinterface

// File: rtl/tone_generator_sample_handshake.sv
// Sample-rate divider, strobe capture of the audio level, valid/ready
// holding register and sticky overrun flag.
module sample_handshake #(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SAMPLE_HZ = 22_050
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] audio_data,
    input  logic       sample_ready,
    output logic [7:0] sample_data,
    output logic       sample_valid,
    output logic       overrun
);

    localparam int unsigned DIVIDER = CLK_HZ / SAMPLE_HZ;
    localparam int          DIV_W   = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVIDER - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             strobe;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        strobe = (div_q == DIV_LAST);
        div_d  = strobe ? '0 : div_q + DIV_W'(1);
    end

    // A strobe wins over an acceptance in the same cycle, so valid stays up with fresh data.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (strobe) begin
            data_d  = audio_data;
            valid_d = 1'b1;
            if (valid_q && !sample_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: rtl/tone_generator.sv
// Square-wave note generator with sampled output handshake.
// Define TONE_SYNC_EN to pass the switches through a two-flop synchronizer.
module tone_generator
    import ipod_audio_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned SAMPLE_HZ = 22_050,
    parameter logic [7:0]  AMPLITUDE = 8'h40
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       SW,
    output logic [7:0]       audio_data,
    tone_generator_if.master sample_if
);

    localparam logic [7:0] NEG_AMPLITUDE = ~AMPLITUDE + 8'd1;

    logic [3:0] sw_use;
    logic       unused_sw;

    assign unused_sw = ^SW[7:4];

`ifdef TONE_SYNC_EN
    logic [3:0] sw_meta_q, sw_meta_d;
    logic [3:0] sw_sync_q, sw_sync_d;

    always_comb begin
        sw_meta_d = SW[3:0];
        sw_sync_d = sw_meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q <= 4'h0;
            sw_sync_q <= 4'h0;
        end else begin
            sw_meta_q <= sw_meta_d;
            sw_sync_q <= sw_sync_d;
        end
    end

    assign sw_use = sw_sync_q;
`else
    assign sw_use = SW[3:0];
`endif

    logic  enable;
    tone_t tone_sel;

    assign enable   = sw_use[0];
    assign tone_sel = tone_t'(sw_use[3:1]);

    logic [15:0] half_table [8];

    for (genvar g = 0; g < 8; g++) begin : g_half
        assign half_table[g] = half_period(tone_t'(g), CLK_HZ);
    end

    tone_state_e state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] half_q, half_d;
    logic        phase_q, phase_d;
    logic [7:0]  audio_q, audio_d;

    // The active half-period only reloads at a boundary, so a tone change never shortens a half.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        half_d  = half_q;
        phase_d = phase_q;
        audio_d = audio_q;
        case (state_q)
            IDLE: begin
                count_d = 16'd0;
                phase_d = 1'b1;
                audio_d = 8'h00;
                if (enable) begin
                    state_d = RUN;
                    half_d  = half_table[tone_sel];
                    audio_d = AMPLITUDE;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    count_d = 16'd0;
                    phase_d = 1'b1;
                    audio_d = 8'h00;
                end else if (count_q == half_q - 16'd1) begin
                    count_d = 16'd0;
                    phase_d = !phase_q;
                    half_d  = half_table[tone_sel];
                    audio_d = phase_q ? NEG_AMPLITUDE : AMPLITUDE;
                end else begin
                    count_d = count_q + 16'd1;
                    audio_d = phase_q ? AMPLITUDE : NEG_AMPLITUDE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= 16'd0;
            half_q  <= 16'd0;
            phase_q <= 1'b1;
            audio_q <= 8'h00;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            audio_q <= audio_d;
        end
    end

    assign audio_data = audio_q;

    sample_handshake #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ)
    ) u_handshake (
        .clk          (clk),
        .reset_n      (reset_n),
        .audio_data   (audio_q),
        .sample_ready (sample_if.sample_ready),
        .sample_data  (sample_if.sample_data),
        .sample_valid (sample_if.sample_valid),
        .overrun      (sample_if.overrun)
    );

endmodule

// File: tb/tb_tone_generator.sv
// Self-checking bench for tone_generator: directed half-period measurements
// plus randomized switch/ready traffic against a behavioural model.
module tb_tone_generator;

    localparam int unsigned CLK_HZ    = 1_000_000;
    localparam int unsigned SAMPLE_HZ = 22_050;
    localparam int unsigned DIV       = CLK_HZ / SAMPLE_HZ;
    localparam logic [7:0]  AMP       = 8'h40;
    localparam logic [7:0]  NEG_AMP   = 8'hC0;
    localparam int          BOUND     = 5000;
`ifdef TONE_SYNC_EN
    localparam int          SW_LAT    = 2;
`else
    localparam int          SW_LAT    = 0;
`endif
    localparam int unsigned NOTE_HZ [8] = '{523, 587, 659, 698, 783, 880, 987, 1046};

    logic       clk;
    logic       reset_n;
    logic [7:0] SW;
    logic [7:0] audio_data;

    tone_generator_if sif ();

    tone_generator #(
        .CLK_HZ    (CLK_HZ),
        .SAMPLE_HZ (SAMPLE_HZ),
        .AMPLITUDE (AMP)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .SW         (SW),
        .audio_data (audio_data),
        .sample_if  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural reference: square wave described as level plus cycles left in the half.
    logic [7:0] m_audio, m_data;
    bit         m_valid, m_overrun, m_running, m_high;
    int         m_left, m_cyc;
    logic [7:0] m_sync1, m_sync2;

    function automatic int half_of(input int tone);
        return int'(CLK_HZ / (2 * NOTE_HZ[tone]));
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
    endtask

    task automatic model_reset();
        m_audio = 8'h00; m_data = 8'h00;
        m_valid = 0; m_overrun = 0; m_running = 0; m_high = 1;
        m_left = 0; m_cyc = 0; m_sync1 = 8'h00; m_sync2 = 8'h00;
    endtask

    task automatic model_edge();
        logic [7:0] sw_eff;
        bit         strobe;
        sw_eff = (SW_LAT == 2) ? m_sync2 : SW;
        m_sync2 = m_sync1;
        m_sync1 = SW;
        strobe = ((m_cyc % DIV) == DIV - 1);
        m_cyc++;
        if (strobe) begin
            if (m_valid && !sif.sample_ready) m_overrun = 1;
            m_data  = m_audio;
            m_valid = 1;
        end else if (m_valid && sif.sample_ready) begin
            m_valid = 0;
        end
        if (!sw_eff[0]) begin
            m_running = 0;
            m_audio   = 8'h00;
        end else if (!m_running) begin
            m_running = 1;
            m_high    = 1;
            m_left    = half_of(int'(sw_eff[3:1])) - 1;
            m_audio   = AMP;
        end else if (m_left == 0) begin
            m_high  = !m_high;
            m_left  = half_of(int'(sw_eff[3:1])) - 1;
            m_audio = m_high ? AMP : NEG_AMP;
        end else begin
            m_left--;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_output("audio_data", audio_data, m_audio);
        check_output("sample_data", sif.sample_data, m_data);
        check_output("sample_valid", sif.sample_valid, m_valid);
        check_output("overrun", sif.overrun, m_overrun);
    endtask

    task automatic apply_stimulus(input logic [7:0] sw_val, input logic ready_val);
        SW = sw_val;
        sif.sample_ready = ready_val;
    endtask

    task automatic wait_level(input string tag, input logic [7:0] level);
        int waited = 0;
        while (audio_data !== level && waited < BOUND) begin
            step();
            waited++;
        end
        check_output(tag, 32'(audio_data === level), 32'd1);
    endtask

    task automatic measure_run(input string tag, input logic [7:0] level, output int len);
        wait_level(tag, level);
        len = 0;
        while (audio_data === level && len < BOUND) begin
            len++;
            step();
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        int cnt;
        reset_n = 1'b0;
        apply_stimulus(8'h00, 1'b0);
        model_reset();
        #23;
        check_output("reset_audio", audio_data, 8'h00);
        check_output("reset_sample_data", sif.sample_data, 8'h00);
        check_output("reset_valid", sif.sample_valid, 1'b0);
        check_output("reset_overrun", sif.overrun, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        apply_stimulus(8'h01, 1'b1);
        measure_run("tone0_start", AMP, len);
        check_output("tone0_high_len", len, half_of(0));
        measure_run("tone0_low_start", NEG_AMP, len);
        check_output("tone0_low_len", len, half_of(0));

        cnt = 0;
        for (int i = 0; i < 10 * int'(DIV); i++) begin
            step();
            if (sif.sample_valid === 1'b1) cnt++;
        end
        check_output("valid_pulses", cnt, 10);
        check_output("ready1_overrun", sif.overrun, 1'b0);

        wait_level("pre_switch_low", NEG_AMP);
        wait_level("pre_switch_high", AMP);
        cnt = 0;
        while (audio_data === AMP && cnt < BOUND) begin
            cnt++;
            if (cnt == 300) SW = 8'h0B;
            step();
        end
        check_output("switch_old_half", cnt, half_of(0));
        measure_run("switch_low_start", NEG_AMP, len);
        check_output("switch_new_low", len, half_of(5));
        measure_run("switch_high_start", AMP, len);
        check_output("switch_new_high", len, half_of(5));

        wait_level("pre_disable_high", AMP);
        repeat (100) step();
        SW = 8'h0A;
        repeat (SW_LAT + 1) step();
        check_output("disable_audio_zero", audio_data, 8'h00);
        repeat (20) step();
        SW = 8'h0B;
        measure_run("reenable_start", AMP, len);
        check_output("reenable_half", len, half_of(5));

        sif.sample_ready = 1'b0;
        repeat (2 * int'(DIV) + 1) step();
        check_output("overrun_set", sif.overrun, 1'b1);
        check_output("overrun_newer_data", sif.sample_data, m_data);

        apply_stimulus(8'h03, 1'b1);
        repeat (200) step();
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_output("async_reset_audio", audio_data, 8'h00);
        check_output("async_reset_data", sif.sample_data, 8'h00);
        check_output("async_reset_valid", sif.sample_valid, 1'b0);
        check_output("async_reset_overrun", sif.overrun, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 149) == 0) SW[0] = ~SW[0];
            if ($urandom_range(0, 249) == 0) SW[7:1] = 7'($urandom);
            sif.sample_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
